// File: rtl/mmio_done_port.sv
// mmio_done_port: MMIO RESULT/CYCLES/LOG/STATUS window with a RUN->DONE latch.
// Optional write-log FIFO is built only when MMIO_DONE_LOG_EN is defined.
module mmio_done_port #(
  parameter logic [31:0] BASE_ADDR = 32'd232,
  parameter int          LOG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Done,
  output logic [31:0] Result,
  output logic        Overflow
);
  localparam int PW = $clog2(LOG_DEPTH);
  localparam int CW = PW + 1;
  // STATUS count field is 2 bits up to depth 4, full count width beyond
  localparam int SW = (LOG_DEPTH <= 4) ? 2 : CW;
  typedef enum logic {RUN, DONE} state_t;
  state_t          r_state;
  logic [31:0]     r_cycles;
  logic [31:0]     w_off;
  logic [1:0]      w_sel;
  logic            w_log_wr;
  logic            w_log_rd;
  logic            w_empty;
  logic            w_full;
  logic [CW-1:0]   w_count;
  logic [31:0]     w_head;
  logic [31:0]     w_status;
  assign w_off    = DataAdr - BASE_ADDR;
  assign Hit      = (w_off < 32'd16) && (DataAdr[1:0] == 2'b00);
  assign w_sel    = w_off[3:2];
  assign w_log_wr = Hit && MemWrite && (w_sel == 2'd2);
  assign w_log_rd = Hit && MemRead && !MemWrite && (w_sel == 2'd2);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      Done     <= 1'b0;
      Result   <= '0;
      r_cycles <= '0;
    end else if (r_state == RUN) begin
      r_cycles <= (&r_cycles) ? r_cycles : r_cycles + 32'd1;
      if (Hit && MemWrite && (w_sel == 2'd0)) begin
        r_state <= DONE;
        Done    <= 1'b1;
        Result  <= WriteData;
      end
    end
  end
`ifdef MMIO_DONE_LOG_EN
  logic [31:0]   r_mem [LOG_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(LOG_DEPTH));
  assign w_count  = r_count;
  assign w_head   = w_empty ? '0 : r_mem[r_rp];
  assign Overflow = r_ovf;
  always_ff @(posedge clk)
    if (w_log_wr && !w_full) r_mem[r_wp] <= WriteData;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_log_wr) begin
      if (w_full) r_ovf <= 1'b1;
      else begin
        r_wp    <= r_wp + 1'b1;
        r_count <= r_count + 1'b1;
      end
    end else if (w_log_rd && !w_empty) begin
      r_rp    <= r_rp + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, w_log_wr, w_log_rd};
  assign w_empty  = 1'b1;
  assign w_full   = 1'b0;
  assign w_count  = '0;
  assign w_head   = '0;
  assign Overflow = 1'b0;
`endif
  assign w_status = {{(28-SW){1'b0}}, Overflow, Done, w_full, w_empty, w_count[SW-1:0]};
  always_comb
    ReadData = !Hit ? '0 : (w_sel == 2'd0) ? Result : (w_sel == 2'd1) ? r_cycles :
               (w_sel == 2'd2) ? w_head : w_status;
endmodule

// File: tb/tb_mmio_done_port.sv
// tb_mmio_done_port: table-driven check of the MMIO done port, both build variants.
module tb_mmio_done_port;
`ifdef MMIO_DONE_LOG_EN
  localparam bit LE = 1'b1;
`else
  localparam bit LE = 1'b0;
`endif
  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        hit;
    logic        done;
    logic [31:0] res;
    logic        ovf;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic        Hit;
  logic        Done;
  logic [31:0] Result;
  logic        Overflow;
  int n_checks = 0;
  int n_fail = 0;
  vec_t tv[40];
  mmio_done_port dut (
    .clk(clk), .reset(reset), .DataAdr(DataAdr), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Hit(Hit),
    .Done(Done), .Result(Result), .Overflow(Overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] adr, input logic [31:0] wd, input logic we,
                              input logic re, input logic [31:0] rd, input logic hit,
                              input logic done, input logic [31:0] res, input logic ovf);
    vec_t v;
    v.adr = adr; v.wd = wd; v.we = we; v.re = re; v.rd = rd;
    v.hit = hit; v.done = done; v.res = res; v.ovf = ovf;
    return v;
  endfunction
  task automatic drive(input logic [31:0] adr, input logic [31:0] wd, input logic we, input logic re);
    DataAdr = adr; WriteData = wd; MemWrite = we; MemRead = re;
  endtask
  initial begin
    for (int i = 0; i < 10; i++) tv[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[10] = mk(236, 0, 0, 1, 10, 1, 0, 0, 0);
    tv[11] = mk(244, 0, 0, 1, 32'h04, 1, 0, 0, 0);
    tv[12] = mk(233, 99, 1, 0, 0, 0, 0, 0, 0);
    tv[13] = mk(260, 99, 1, 1, 0, 0, 0, 0, 0);
    tv[14] = mk(232, 25, 1, 0, 0, 1, 1, 25, 0);
    tv[15] = mk(236, 0, 0, 1, 15, 1, 1, 25, 0);
    tv[16] = mk(232, 7, 1, 0, 25, 1, 1, 25, 0);
    tv[17] = mk(232, 0, 0, 1, 25, 1, 1, 25, 0);
    tv[18] = mk(236, 0, 1, 0, 15, 1, 1, 25, 0);
    tv[19] = mk(236, 0, 0, 1, 15, 1, 1, 25, 0);
    tv[20] = mk(244, 0, 0, 1, 32'h14, 1, 1, 25, 0);
    tv[21] = mk(240, 1, 1, 0, 0, 1, 1, 25, 0);
    tv[22] = mk(240, 2, 1, 0, LE ? 1 : 0, 1, 1, 25, 0);
    tv[23] = mk(240, 3, 1, 0, LE ? 1 : 0, 1, 1, 25, 0);
    tv[24] = mk(240, 4, 1, 0, LE ? 1 : 0, 1, 1, 25, 0);
    tv[25] = mk(240, 5, 1, 0, LE ? 1 : 0, 1, 1, 25, LE);
    tv[26] = mk(244, 0, 0, 1, LE ? 32'h38 : 32'h14, 1, 1, 25, LE);
    tv[27] = mk(240, 0, 0, 1, LE ? 1 : 0, 1, 1, 25, LE);
    tv[28] = mk(240, 0, 0, 1, LE ? 2 : 0, 1, 1, 25, LE);
    tv[29] = mk(240, 0, 0, 1, LE ? 3 : 0, 1, 1, 25, LE);
    tv[30] = mk(240, 0, 0, 1, LE ? 4 : 0, 1, 1, 25, LE);
    tv[31] = mk(240, 0, 0, 1, 0, 1, 1, 25, LE);
    tv[32] = mk(244, 0, 0, 1, LE ? 32'h34 : 32'h14, 1, 1, 25, LE);
    tv[33] = mk(240, 9, 1, 0, 0, 1, 1, 25, LE);
    tv[34] = mk(244, 0, 0, 1, LE ? 32'h31 : 32'h14, 1, 1, 25, LE);
    tv[35] = mk(240, 10, 1, 1, LE ? 9 : 0, 1, 1, 25, LE);
    tv[36] = mk(244, 0, 0, 1, LE ? 32'h32 : 32'h14, 1, 1, 25, LE);
    tv[37] = mk(240, 0, 0, 1, LE ? 9 : 0, 1, 1, 25, LE);
    tv[38] = mk(240, 0, 0, 1, LE ? 10 : 0, 1, 1, 25, LE);
    tv[39] = mk(244, 0, 0, 1, LE ? 32'h34 : 32'h14, 1, 1, 25, LE);
    repeat (2) @(posedge clk);
    #1;
    check("rst Done", {31'b0, Done}, 0);
    check("rst Result", Result, 0);
    check("rst Overflow", {31'b0, Overflow}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(tv[i].adr, tv[i].wd, tv[i].we, tv[i].re);
      #1;
      check($sformatf("row%0d ReadData", i), ReadData, tv[i].rd);
      check($sformatf("row%0d Hit", i), {31'b0, Hit}, {31'b0, tv[i].hit});
      @(posedge clk);
      #1;
      check($sformatf("row%0d Done", i), {31'b0, Done}, {31'b0, tv[i].done});
      check($sformatf("row%0d Result", i), Result, tv[i].res);
      check($sformatf("row%0d Overflow", i), {31'b0, Overflow}, {31'b0, tv[i].ovf});
      @(negedge clk);
    end
    drive(240, 11, 1, 0);
    @(posedge clk);
    @(negedge clk);
    drive(240, 12, 1, 0);
    @(posedge clk);
    @(negedge clk);
    drive(244, 0, 0, 1);
    #1;
    check("pre-rst STATUS", ReadData, LE ? 32'h32 : 32'h14);
    #1;
    reset = 1'b0;
    #1;
    check("midrst Done", {31'b0, Done}, 0);
    check("midrst Result", Result, 0);
    check("midrst Overflow", {31'b0, Overflow}, 0);
    check("midrst STATUS", ReadData, 32'h04);
    drive(236, 0, 0, 1);
    #1;
    check("midrst CYCLES", ReadData, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(244, 0, 0, 0);
    #1;
    check("post-rst STATUS", ReadData, 32'h04);
    drive(240, 0, 0, 0);
    #1;
    check("post-rst LOG", ReadData, 0);
    drive(236, 0, 0, 0);
    @(posedge clk);
    #1;
    check("first CYCLES", ReadData, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_done_port.md
MMIO_DONE_PORT -- requirements
Module: mmio_done_port

Interface
REQ-001 Parameter BASE_ADDR, default 32'd232: byte address of the RESULT register; CYCLES=BASE+4, LOG=BASE+8, STATUS=BASE+12.
REQ-002 Parameter LOG_DEPTH, default 4: write-log FIFO depth, power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 DataAdr  input  32  processor data-bus byte address.
REQ-006 WriteData  input  32  processor store data.
REQ-007 MemWrite  input  1  store strobe, one cycle per store.
REQ-008 MemRead  input  1  load strobe, one cycle per load.
REQ-009 ReadData  output  32  load data, combinational from DataAdr and registered state.
REQ-010 Hit  output  1  DataAdr within BASE..BASE+15, word-aligned.
REQ-011 Done  output  1  registered; high in DONE state.
REQ-012 Result  output  32  registered copy of the captured result word.
REQ-013 Overflow  output  1  registered, sticky: a LOG push was dropped.

Function
REQ-014 FSM states RUN and DONE only; RUN after reset release.
REQ-015 RUN -> DONE on the first edge with MemWrite=1 and DataAdr=BASE; Result<=WriteData on the same edge; Done high the next cycle.
REQ-016 DONE is terminal until reset; later RESULT stores are ignored (first write wins).
REQ-017 CYCLES: 32-bit counter, +1 per edge in RUN, frozen in DONE, saturates at 32'hFFFFFFFF; stores to CYCLES are ignored.
REQ-018 LOG store (MemWrite, DataAdr=LOG): push WriteData if not full; if full, drop the data and set Overflow.
REQ-019 LOG load (MemRead, DataAdr=LOG): ReadData = head entry (0 if empty); pop on that edge if not empty; empty pop has no effect.
REQ-020 STATUS read = {26'b0, Overflow, Done, full, empty, count[1:0]} for LOG_DEPTH=4; count field widens to log2(LOG_DEPTH)+1 bits for larger depths, with the upper constant-zero field shrinking to match; STATUS stores are ignored.
REQ-021 MemWrite and MemRead high in the same cycle: the store is performed, the load side effect (pop) is suppressed.
REQ-022 Misaligned address (DataAdr[1:0]!=0) or out-of-window address: Hit=0, ReadData=0, no state change.
REQ-023 FIFO pointers wrap modulo LOG_DEPTH; full = count==LOG_DEPTH; empty = count==0.
REQ-024 Logging continues in DONE state; only the FSM and CYCLES freeze.

Reset
REQ-025 reset low asynchronously forces state=RUN, Done=0, Result=0, CYCLES=0, Overflow=0, FIFO pointers and count=0.
REQ-026 Reset asserted mid-operation discards all FIFO contents and any captured result; FIFO storage contents need not be cleared.
REQ-027 First CYCLES increment occurs on the first rising edge with reset high.

Configuration
REQ-028 Macro MMIO_DONE_LOG_EN present: LOG FIFO, Overflow and STATUS fifo fields are implemented as above.
REQ-029 Macro absent: no FIFO storage; LOG stores ignored; LOG reads return 0; Overflow tied 0; STATUS reports empty=1, full=0, count=0; Hit still decodes LOG.

Verification
REQ-030 Release reset, idle 10 cycles, load CYCLES -> ReadData=10 (+/- bus sample point fixed by bench), Done=0.
REQ-031 Store 32'd25 to 232 -> next cycle Done=1, Result=25; then store 32'd7 to 232 -> Result remains 25; CYCLES frozen.
REQ-032 (LOG_EN) Push 1,2,3,4,5 to 240 -> STATUS full=1, count=4, Overflow=1; pop 4 times -> reads 1,2,3,4; 5th pop -> 0, empty=1.
REQ-033 Store to 233 (misaligned) and to 260 -> Hit=0, no change to Result, FIFO, Done.
REQ-034 Push 2 entries, assert reset low between edges -> Done, Overflow, count, CYCLES immediately 0; STATUS empty=1 after release.
REQ-035 MemWrite and MemRead both high at 240 with FIFO holding one entry -> count becomes 2, no pop.
